// File: rtl/csr_byte_bridge_pkg.sv
// Shared opcodes, response codes and FSM state type for the CSR byte bridge.
package csr_byte_bridge_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;

  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_TMO = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_RSP
  } state_e;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/csr_byte_bridge_rsp_serializer.sv
// Response serializer: parallel load of up to four bytes, emitted MSB first
// over valid/ready; done pulses with the transfer of the last byte.
module csr_rsp_serializer
  import csr_byte_bridge_pkg::*;
(
  input  logic        reg_clk_i,
  input  logic        reg_rst_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic [2:0]  load_cnt_i,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        done_o
);

  logic [31:0] shreg_q;
  logic [2:0]  left_q;
  logic        fire;

  assign rsp_data_o  = shreg_q[31:24];
  assign rsp_valid_o = (left_q != '0);
  assign fire        = rsp_valid_o && rsp_ready_i;
  assign done_o      = fire && (left_q == 3'd1);

  always_ff @(posedge reg_clk_i) begin
    if (reg_rst_i) begin
      shreg_q <= '0;
      left_q  <= '0;
    end else if (load_i) begin
      shreg_q <= load_data_i;
      left_q  <= load_cnt_i;
    end else if (fire) begin
      shreg_q <= {shreg_q[23:0], 8'h00};
      left_q  <= left_q - 3'd1;
    end
  end

endmodule

// File: rtl/csr_byte_bridge.sv
// Byte-stream command parser driving single-cycle CSR write/read strobes,
// returning ack/read-data/error/timeout bytes through the response serializer.
module csr_byte_bridge
  import csr_byte_bridge_pkg::*;
#(
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        reg_clk_i,
  input  logic        reg_rst_i,
  input  logic [7:0]  cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] reg_wr_data_o,
  output logic        reg_wr_en_o,
  output logic        reg_rd_en_o,
  output logic [7:0]  reg_addr_o,
  input  logic [31:0] reg_rd_data_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LATENCY - 1);

  state_e        state_q, state_d;
  logic          accepting, cmd_fire;
  logic          is_rd_q;
  logic [1:0]    byte_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [WW-1:0] wait_cnt_q;
  logic [7:0]    addr_q;
  logic [31:0]   wdata_q;
  logic          in_cmd, tmo_hit, wait_done;
  logic          ser_load, ser_done;
  logic [31:0]   ser_data;
  logic [2:0]    ser_cnt;

  assign accepting   = !reg_rst_i &&
                       (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
  assign cmd_ready_o = accepting;
  assign cmd_fire    = cmd_valid_i && accepting;

  assign in_cmd    = (state_q == S_ADDR) || (state_q == S_DATA);
  // Firing one count early makes the FSM leave on the edge where the counter
  // would reach TIMEOUT_CYCLES, so no byte can be accepted past the deadline.
  assign tmo_hit   = in_cmd && !cmd_fire && (tmo_cnt_q == TMO_LAST);
  assign wait_done = (state_q == S_RD_WAIT) && (wait_cnt_q == WAIT_LAST);

  assign reg_addr_o    = addr_q;
  assign reg_wr_data_o = wdata_q;

  always_ff @(posedge reg_clk_i) begin
    if (reg_rst_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (cmd_fire) state_d = is_known_op(cmd_data_i) ? S_ADDR : S_RSP;
      S_ADDR:    if (cmd_fire) state_d = is_rd_q ? S_RD : S_DATA;
                 else if (tmo_hit) state_d = S_RSP;
      S_DATA:    if (cmd_fire && byte_cnt_q == 2'd3) state_d = S_WR;
                 else if (tmo_hit) state_d = S_RSP;
      S_WR:      state_d = S_RSP;
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: if (wait_done) state_d = S_RSP;
      S_RSP:     if (ser_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_wr_en_o = 1'b0;
    reg_rd_en_o = 1'b0;
    ser_load    = 1'b0;
    ser_data    = '0;
    ser_cnt     = 3'd1;
    unique case (state_q)
      S_IDLE:
        if (cmd_fire && !is_known_op(cmd_data_i)) begin
          ser_load = 1'b1;
          ser_data = {RSP_ERR, 24'h0};
        end
      S_ADDR, S_DATA:
        if (tmo_hit) begin
          ser_load = 1'b1;
          ser_data = {RSP_TMO, 24'h0};
        end
      S_WR: begin
        reg_wr_en_o = 1'b1;
        ser_load    = 1'b1;
        ser_data    = {RSP_ACK, 24'h0};
      end
      S_RD: reg_rd_en_o = 1'b1;
      S_RD_WAIT:
        if (wait_done) begin
          ser_load = 1'b1;
          ser_data = reg_rd_data_i;
          ser_cnt  = 3'd4;
        end
      default: ;
    endcase
  end

  always_ff @(posedge reg_clk_i) begin
    if (reg_rst_i) begin
      is_rd_q    <= 1'b0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if (state_q == S_IDLE && cmd_fire) is_rd_q <= (cmd_data_i == OP_RD);
      if (state_q == S_ADDR && cmd_fire) addr_q <= cmd_data_i;

      if (state_q == S_DATA) begin
        if (cmd_fire) begin
          wdata_q    <= {wdata_q[23:0], cmd_data_i};
          byte_cnt_q <= byte_cnt_q + 2'd1;
        end
      end else begin
        byte_cnt_q <= '0;
      end

      if (in_cmd) begin
        if (cmd_fire)                tmo_cnt_q <= '0;
        else if (tmo_cnt_q != TMO_MAX) tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end else begin
        tmo_cnt_q <= '0;
      end

      if (state_q == S_RD_WAIT) wait_cnt_q <= wait_cnt_q + WW'(1);
      else                      wait_cnt_q <= '0;
    end
  end

  csr_rsp_serializer u_ser (
    .reg_clk_i   (reg_clk_i),
    .reg_rst_i   (reg_rst_i),
    .load_i      (ser_load),
    .load_data_i (ser_data),
    .load_cnt_i  (ser_cnt),
    .rsp_data_o  (rsp_data_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .done_o      (ser_done)
  );

endmodule

// File: tb/tb_csr_byte_bridge.sv
// Directed + randomized bench for csr_byte_bridge with a CSR slave model and
// a reference memory/response queue derived from the commands sent.
module tb_csr_byte_bridge;

  localparam int unsigned RD_LAT = 1;
  localparam int unsigned TMO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] wr_data_o;
  logic        wr_en, rd_en;
  logic [7:0]  addr_o;
  logic [31:0] rd_data = '0;

  csr_byte_bridge #(.RD_LATENCY(RD_LAT), .TIMEOUT_CYCLES(TMO)) dut (
    .reg_clk_i     (clk),
    .reg_rst_i     (rst),
    .cmd_data_i    (cmd_data),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .rsp_data_o    (rsp_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .reg_wr_data_o (wr_data_o),
    .reg_wr_en_o   (wr_en),
    .reg_rd_en_o   (rd_en),
    .reg_addr_o    (addr_o),
    .reg_rd_data_i (rd_data)
  );

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ready_mode = 0;
  int wr_cnt, rd_cnt, wr_cyc, rd_cyc, first_cyc;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_dat;
  logic [7:0]  rsp_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_mem [256];
  logic [31:0] csr_mem [256];

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 1) ? 32'hC0FF0015 : {b, ~b, b ^ 8'h5A, 8'hA5};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #400000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1);
  end

  // Response sink ready pattern, changed just after each edge.
  initial forever begin
    @(posedge clk); #2;
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ~rsp_ready;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // CSR slave: registered read data, garbage outside the valid cycle.
  initial begin
    logic [31:0] nxt;
    for (int i = 0; i < 256; i++) csr_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (wr_en) csr_mem[addr_o] = wr_data_o;
      nxt = rd_en ? csr_mem[addr_o] : $urandom;
      @(posedge clk);
      rd_data <= nxt;
    end
  end

  // Per-cycle monitor: strobe exclusivity/width, response hold, byte capture.
  initial begin
    logic pwr, prd, pval, prdy;
    logic [7:0] pdat;
    pwr = 0; prd = 0; pval = 0; prdy = 0; pdat = '0;
    forever begin
      @(posedge clk); #3;
      if (!rst) begin
        if (wr_en) begin
          check("wr_excl", 32'(rd_en), 32'd0);
          check("wr_width", 32'(pwr), 32'd0);
          wr_cnt++; wr_cyc = cyc; wr_addr = addr_o; wr_dat = wr_data_o;
        end
        if (rd_en) begin
          check("rd_width", 32'(prd), 32'd0);
          rd_cnt++; rd_cyc = cyc; rd_addr = addr_o;
        end
        if (pval && !prdy) begin
          check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          check("rsp_hold_data", 32'(rsp_data), 32'(pdat));
        end
        if (rsp_valid && !pval && first_cyc < 0) first_cyc = cyc;
        if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
        pwr = wr_en; prd = rd_en; pval = rsp_valid; prdy = rsp_ready; pdat = rsp_data;
      end else begin
        pwr = 0; prd = 0; pval = 0; prdy = 0;
      end
    end
  end

  task automatic begin_cmd();
    rsp_q.delete(); exp_q.delete();
    wr_cnt = 0; rd_cnt = 0; first_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    cmd_data = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    int n;
    logic [7:0] obs;
    n = 0;
    while (rsp_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    idle(4);
    check({tag, "_rsp_len"}, 32'(rsp_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < rsp_q.size()) ? rsp_q[i] : 8'hxx;
      check({tag, "_rsp_byte"}, 32'(obs), 32'(exp_q[i]));
    end
    check({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d, input int maxgap);
    logic [31:0] sh;
    begin_cmd();
    idle($urandom_range(0, maxgap)); send_byte(8'h57);
    idle($urandom_range(0, maxgap)); send_byte(a);
    sh = d;
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, maxgap));
      send_byte(sh[31:24]);
      sh = sh << 8;
    end
    exp_q.push_back(8'h4B);
    exp_mem[a] = d;
    finish_cmd(tag);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd1);
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'(a));
    check({tag, "_wr_data"}, wr_dat, d);
    check({tag, "_wr_cyc"}, 32'(wr_cyc), 32'(acc_cyc));
    check({tag, "_rsp_first"}, 32'(first_cyc), 32'(acc_cyc + 1));
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input int maxgap);
    logic [31:0] v;
    begin_cmd();
    idle($urandom_range(0, maxgap)); send_byte(8'h52);
    idle($urandom_range(0, maxgap)); send_byte(a);
    v = exp_mem[a];
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'(v >> (8 * i)));
    finish_cmd(tag);
    check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd1);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'(a));
    check({tag, "_rd_cyc"}, 32'(rd_cyc), 32'(acc_cyc));
    check({tag, "_rsp_first"}, 32'(first_cyc), 32'(acc_cyc + 1 + int'(RD_LAT)));
  endtask

  task automatic do_bad(input string tag, input logic [7:0] op);
    begin_cmd();
    send_byte(op);
    exp_q.push_back(8'h45);
    finish_cmd(tag);
    check({tag, "_strobes"}, 32'(wr_cnt + rd_cnt), 32'd0);
    check({tag, "_rsp_first"}, 32'(first_cyc), 32'(acc_cyc));
  endtask

  initial begin
    logic [7:0] op;
    int kind;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    begin_cmd();

    // Reset values while reset is held.
    rst = 1'b1;
    idle(3);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_wr_data", wr_data_o, 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Plan: write 57 00 00 00 80 2A with ready held high.
    ready_mode = 0;
    do_write("plan_wr", 8'h00, 32'h0000802A, 0);
    check("plan_wr_held", wr_data_o, 32'h0000802A);

    // Plan: read 52 01 with toggling sink ready.
    ready_mode = 1;
    do_read("plan_rd", 8'h01, 0);

    // Plan: bad opcode then a normal read.
    ready_mode = 0;
    do_bad("plan_bad", 8'h33);
    do_read("plan_bad_rd", 8'h01, 0);

    // Plan: timeout after 57 05 02.
    begin_cmd();
    send_byte(8'h57); send_byte(8'h05); send_byte(8'h02);
    exp_q.push_back(8'h54);
    finish_cmd("plan_tmo");
    check("plan_tmo_wr_cnt", 32'(wr_cnt), 32'd0);
    check("plan_tmo_first", 32'(first_cyc), 32'(acc_cyc + int'(TMO)));

    // Plan: reset pulse during RD_WAIT, then a write.
    begin_cmd();
    send_byte(8'h52); send_byte(8'h03);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(10);
    check("rstmid_rsp_len", 32'(rsp_q.size()), 32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_rd_cnt", 32'(rd_cnt), 32'd1);
    check("rstmid_ready", 32'(cmd_ready), 32'd1);
    do_write("rstmid_wr", 8'h02, 32'h00000001, 0);
    do_read("rstmid_rd", 8'h02, 0);

    // Randomized command mix with random inter-byte gaps and sink stalls.
    for (int n = 0; n < 40; n++) begin
      ready_mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        do_write("rnd_wr", 8'($urandom_range(0, 15)), $urandom, 3);
      end else if (kind < 9) begin
        do_read("rnd_rd", 8'($urandom_range(0, 15)), 3);
      end else begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
        do_bad("rnd_bad", op);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
